// File: rtl/melody_recorder_player.sv
// ---------------------------------------------------------------------------
// melody_recorder_player
//
// Records the live {note, octave} stream coming from the keypad decoder as a
// list of {note, octave, duration} entries and plays that list back to the
// tone generator.  While idle or recording, the tone generator hears the live
// keys through one register stage.  While playing, it hears the stored buffer.
// Durations are counted in external tick strobes.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   tick_i         one-cycle duration strobe
//   rec_start_i    one-cycle pulse, begin recording (accepted in IDLE only)
//   play_start_i   one-cycle pulse, begin playback (IDLE with count > 0 only)
//   stop_i         one-cycle pulse, end REC or PLAY (wins over the others)
//   key_note_i     live note code (0 = rest, 1..12 = C..B)
//   key_octave_i   live octave (0..9)
//   out_note_o     note to the tone generator
//   out_octave_o   octave to the tone generator
//   state_o        0 = IDLE, 1 = REC, 2 = PLAY
//   count_o        number of valid stored entries
//   full_o         buffer holds DEPTH entries
// ---------------------------------------------------------------------------
module melody_recorder_player #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DUR_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              rec_start_i,
    input  logic              play_start_i,
    input  logic              stop_i,
    input  logic [3:0]        key_note_i,
    input  logic [3:0]        key_octave_i,
    output logic [3:0]        out_note_o,
    output logic [3:0]        out_octave_o,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam int                ENTRY_W    = 8 + DUR_W;
    localparam logic [DUR_W-1:0]  DUR_MAX    = '1;
    localparam logic [DUR_W-1:0]  DUR_ONE    = 1;
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(DEPTH);

    state_t               state_q, state_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [7:0]           cur_q, cur_d;        // key being timed while recording
    logic [DUR_W-1:0]     dur_q, dur_d;        // ticks accumulated for cur_q
    logic [ADDR_W-1:0]    idx_q, idx_d;        // playback entry index
    logic [DUR_W-1:0]     rem_q, rem_d;        // ticks left for the playing entry
    logic                 rd_valid_q, rd_valid_d;  // rd_q holds mem[idx_q]
    logic                 fresh_q, fresh_d;    // rd_q was loaded on the last edge
    logic                 shown_q, shown_d;    // an entry has reached the outputs
    logic [7:0]           keys_q;              // live keys, one stage late

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ENTRY_W-1:0]   rd_q;

    logic                 wr_en;
    logic [ENTRY_W-1:0]   wr_data;
    logic [7:0]           key_w;
    logic                 full_w;
    logic [DUR_W:0]       sum_w;
    logic [DUR_W-1:0]     d_w;
    logic [DUR_W-1:0]     rem_eff_w;
    logic                 last_w;
    logic                 play_show_w;

    always_comb begin
        key_w  = {key_note_i, key_octave_i};
        full_w = (count_q == COUNT_FULL);
        // One extra bit so a tick at the maximum duration cannot wrap.
        sum_w  = {1'b0, dur_q} + {{DUR_W{1'b0}}, tick_i};
        d_w    = sum_w[DUR_W] ? DUR_MAX : sum_w[DUR_W-1:0];
        // The first cycle an entry is visible its duration is still in rd_q.
        rem_eff_w = fresh_q ? rd_q[DUR_W-1:0] : rem_q;
        last_w    = ({1'b0, idx_q} == (count_q - CNT_ONE));

        state_d    = state_q;
        count_d    = count_q;
        cur_d      = cur_q;
        dur_d      = dur_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        shown_d    = shown_q;
        wr_en      = 1'b0;
        wr_data    = {cur_q, d_w};

        unique case (state_q)
            ST_IDLE: begin
                if (!stop_i) begin
                    if (rec_start_i) begin
                        state_d = ST_REC;
                        count_d = '0;
                        cur_d   = key_w;
                        dur_d   = '0;
                    end else if (play_start_i && (count_q != '0)) begin
                        state_d    = ST_PLAY;
                        idx_d      = '0;
                        rd_valid_d = 1'b0;
                        shown_d    = 1'b0;
                    end
                end
            end
            ST_REC: begin
                if (stop_i) begin
                    if ((d_w != '0) && !full_w) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                    state_d = ST_IDLE;
                    dur_d   = '0;
                end else if (key_w != cur_q) begin
                    // A key change with no tick since the last one is dropped.
                    if ((d_w != '0) && !full_w) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                    cur_d = key_w;
                    dur_d = '0;
                end else if (tick_i && (dur_q == DUR_MAX)) begin
                    // Saturated note: store a full-length entry and let the
                    // overflowing tick open the continuation entry, so the
                    // total number of ticks held is preserved.
                    if (!full_w) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                    dur_d = DUR_ONE;
                end else begin
                    dur_d = sum_w[DUR_W-1:0];
                end
                if (wr_en && (count_d == COUNT_FULL)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (!rd_valid_q) begin
                    // RAM read of mem[idx_q] lands at the end of this cycle.
                    rd_valid_d = 1'b1;
                end else begin
                    shown_d = 1'b1;
                    rem_d   = rem_eff_w;
                    if (tick_i) begin
                        rem_d = rem_eff_w - DUR_ONE;
                        if (rem_eff_w == DUR_ONE) begin
                            if (last_w) begin
                                state_d = ST_IDLE;
                            end else begin
                                idx_d      = idx_q + 1'b1;
                                rd_valid_d = 1'b0;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fresh_d = rd_valid_d & ~rd_valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            cur_q      <= '0;
            dur_q      <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            fresh_q    <= 1'b0;
            shown_q    <= 1'b0;
            keys_q     <= {4'd0, 4'd4};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            dur_q      <= dur_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            fresh_q    <= fresh_d;
            shown_q    <= shown_d;
            keys_q     <= key_w;
        end
    end

    // Buffer: write port at the record pointer, registered read at idx_q.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= wr_data;
        end
        rd_q <= mem[idx_q];
    end

    // Until the first entry arrives after play_start the live path stays
    // selected; afterwards the previous entry is held across index changes.
    assign play_show_w  = (state_q == ST_PLAY) && (shown_q || rd_valid_q);
    assign out_note_o   = play_show_w ? rd_q[ENTRY_W-1 -: 4] : keys_q[7:4];
    assign out_octave_o = play_show_w ? rd_q[DUR_W+3 -: 4]   : keys_q[3:0];
    assign state_o      = state_q;
    assign count_o      = count_q;
    assign full_o       = full_w;

endmodule
